// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter, next-PC select and run-control FSM
module prog_ctr #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          abs_jump,
  input  logic [D-1:0]  target,
  input  logic          rel_branch,
  input  logic [D-1:0]  offset,
  input  logic          cond,
  input  logic          halt,
  output logic [D-1:0]  pc,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state, state_n;
  logic [D-1:0]  pc_n;
  logic [CW-1:0] cnt_n;

  // State, PC and cycle counter registers; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      cycle_cnt <= cnt_n;
    end
  end

  // Next-state, next-PC and counter selection with strict RUN priority
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cycle_cnt;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          pc_n    = start_addr;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        // Every RUN edge counts, including stalls and the halt edge; saturate
        if (!(&cycle_cnt)) begin
          cnt_n = cycle_cnt + CNT_ONE;
        end
        if (stall) begin
          pc_n = pc;
        end else if (halt) begin
          state_n = HALTED;
        end else if (abs_jump && cond) begin
          pc_n = target;
        end else if (rel_branch && cond) begin
          // Modular D-bit add handles negative offsets without sign extension
          pc_n = pc + offset;
        end else begin
          pc_n = pc + PC_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore status outputs decoded from the state register only
  always_comb begin
    running = (state == RUN);
    done    = (state == HALTED);
  end

endmodule

// File: doc/prog_ctr.md
Name: prog_ctr

Overview:
Program counter and next-PC select for the single-cycle core. Holds the fetch address presented to instruction memory each cycle. Chooses between sequential increment, an absolute jump target supplied by the jump-target LUT, and a PC-relative branch offset. A small run-control state machine (IDLE/RUN/HALTED) starts a program at a given address, reports completion and counts executed cycles for the testbench.

Parameters:
D, 12, PC/address width in bits
CW, 16, width of cycle counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high; clears all state immediately
Start  input  1  launch program (pulse); honoured in IDLE and HALTED only
StartAddr  input  D  PC loaded on Start
Stall  input  1  hold current PC; current instruction not retired this cycle
AbsJump  input  1  current instruction is an absolute jump
Target  input  D  absolute target from jump-target LUT
RelBranch  input  1  current instruction is a relative branch
Offset  input  D  two's-complement branch offset
Cond  input  1  branch/jump condition flag; AbsJump/RelBranch taken only when 1
Halt  input  1  current instruction is the done/halt instruction
PC  output  D  current fetch address
Running  output  1  1 while in RUN
Done  output  1  1 while in HALTED
CycleCnt  output  CW  RUN cycles elapsed since last Start

Behaviour:
- Reset (async, any time incl. mid-program): PC=0, state=IDLE, Running=0, Done=0, CycleCnt=0. Deassertion takes effect at next rising edge only.
- States: IDLE, RUN, HALTED. Running/Done are Moore outputs decoded from state register (no combinational path from inputs).
- IDLE: PC holds. Start=1 -> PC<=StartAddr, CycleCnt<=0, state<=RUN. All other inputs ignored.
- RUN, per rising edge, strict priority:
  1. Stall=1 -> PC holds; state stays RUN; Halt/AbsJump/RelBranch ignored this cycle.
  2. Halt=1 -> PC holds; state<=HALTED.
  3. AbsJump=1 and Cond=1 -> PC<=Target.
  4. RelBranch=1 and Cond=1 -> PC<=(PC+Offset) mod 2^D.
  5. otherwise (incl. AbsJump/RelBranch with Cond=0) -> PC<=(PC+1) mod 2^D.
  AbsJump and RelBranch both asserted: AbsJump wins. Start in RUN ignored.
- CycleCnt increments on every rising edge in RUN (stalled cycles included, halt cycle included); saturates at 2^CW-1, never wraps.
- HALTED: PC and CycleCnt hold; Done=1. Start=1 -> same action as in IDLE (reload, clear count, RUN).
- Arithmetic: all PC math D bits, carry discarded. PC=2^D-1 with increment -> 0. Offset is sign-interpreted only by modular addition; no sign extension beyond D needed.
- Latency: next-PC decision uses inputs sampled at the edge; new PC visible on PC immediately after that edge (one cycle from instruction to redirect, no delay slot).
- No X propagation: Target/Offset unused when their select is inactive.

Test Plan:
- Reset then Start with StartAddr=0; 3 unstalled cycles -> PC 0,1,2,3; Running=1; CycleCnt=3.
- At PC=5, AbsJump=1 Cond=1 Target=18 -> next PC=18; same with Cond=0 -> PC=6; AbsJump and RelBranch both set, Cond=1, Target=31 -> PC=31.
- RelBranch Cond=1: PC=20 Offset=0xFFB -> 15; PC=4 Offset=0xFFF -> 3; PC=4 Offset=0x014 -> 24; PC=4095 no branch -> 0.
- Stall=1 for 2 cycles at PC=7 with Halt=1 and AbsJump=1 also high -> PC stays 7, state RUN, CycleCnt +2; drop Stall with Halt=1 -> Done=1 next edge, PC=7 held, CycleCnt frozen.
- In HALTED, Start=1 StartAddr=31 -> PC=31, CycleCnt=0, Running=1, Done=0; Start pulsed again in RUN -> ignored.
- Assert Reset between clock edges mid-run at PC=54 -> PC=0, IDLE, CycleCnt=0 before next edge; force CycleCnt to 0xFFFF in RUN -> stays 0xFFFF.
